// File: rtl/mips_trace_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mips_trace_uart_tx
//  Description : Captures a {PC, instruction} record on every fetch-state
//                entry of the multi-cycle MIPS32 core. Records are buffered
//                in a small FIFO and streamed out as 10-byte UART 8N1 frames:
//                sync byte, PC (MSB first), instruction (MSB first), XOR
//                checksum of the eight payload bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_trace_uart_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trace_valid,
  input  logic [31:0]                   trace_pc,
  input  logic [31:0]                   trace_instr,
  input  logic                          clear_overflow,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    dropped_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] C_FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [3:0]    C_LAST_BYTE = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Record FIFO
  logic [63:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_drop;

  // Serializer
  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_baud_cnt;
  logic [2:0]     r_bit_idx;
  logic [3:0]     r_byte_idx;
  logic [79:0]    r_frame;
  logic [7:0]     w_cur_byte;
  logic           w_tick;
  logic [63:0]    w_rec;
  logic [7:0]     w_cks;
  logic [79:0]    w_frame_load;
  logic           r_overflow;
  logic [7:0]     r_dropped;

  assign w_full  = (r_level == C_FULL_LVL);
  assign w_empty = (r_level == '0);
  // The serializer only takes a record while idle; that slot frees before a
  // same-cycle push is judged, so a full FIFO can still accept.
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_push  = trace_valid && (!w_full || w_pop);
  assign w_drop  = trace_valid && w_full && !w_pop;

  // Frame image with byte 0 in the low bits so bytes leave by shifting right.
  assign w_rec  = r_mem[r_rd_ptr];
  assign w_cks  = w_rec[63:56] ^ w_rec[55:48] ^ w_rec[47:40] ^ w_rec[39:32]
                ^ w_rec[31:24] ^ w_rec[23:16] ^ w_rec[15:8]  ^ w_rec[7:0];
  assign w_frame_load = {w_cks,
                         w_rec[7:0],   w_rec[15:8],  w_rec[23:16], w_rec[31:24],
                         w_rec[39:32], w_rec[47:40], w_rec[55:48], w_rec[63:56],
                         SYNC_BYTE};

  assign w_cur_byte = r_frame[7:0];
  assign w_tick     = (r_baud_cnt == C_BAUD_LAST);

  // FIFO storage; contents need no reset because pointers gate every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {trace_pc, trace_instr};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky drop flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_dropped  <= 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_overflow)          r_dropped <= 8'd1;
      else if (r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
      r_dropped  <= 8'd0;
    end
  end

  // Serializer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Serializer next state and line level.
  always_comb begin
    w_next  = r_state;
    uart_tx = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_next = S_START;
      end
      S_START: begin
        uart_tx = 1'b0;
        if (w_tick) w_next = S_DATA;
      end
      S_DATA: begin
        uart_tx = w_cur_byte[r_bit_idx];
        if (w_tick && (r_bit_idx == 3'd7)) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_tick) w_next = (r_byte_idx == C_LAST_BYTE) ? S_IDLE : S_START;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bit timing, bit/byte indices and the frame shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 4'd0;
      r_frame    <= '0;
    end else if (r_state == S_IDLE) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 4'd0;
      if (w_pop) r_frame <= w_frame_load;
    end else begin
      r_baud_cnt <= w_tick ? '0 : r_baud_cnt + CW'(1);
      if (w_tick && (r_state == S_DATA)) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_tick && (r_state == S_STOP)) begin
        r_byte_idx <= r_byte_idx + 4'd1;
        r_frame    <= {8'h00, r_frame[79:8]};
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign fifo_level    = r_level;
  assign overflow      = r_overflow;
  assign dropped_count = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_mips_trace_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_trace_uart_tx
//  Description : Bench for mips_trace_uart_tx. A queue-based reference model
//                predicts every output each cycle; directed frames are also
//                decoded from the serial line and compared byte by byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_trace_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 100 * CPB;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          trace_valid;
  logic [31:0]   trace_pc;
  logic [31:0]   trace_instr;
  logic          clear_overflow;
  logic          uart_tx;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic [7:0]    dropped_count;

  int n_vectors;
  int n_miscompares;

  // Reference model state
  logic [63:0] m_q[$];
  logic [63:0] m_cur;
  int          m_rem;
  logic        m_ovf;
  int          m_dcnt;

  mips_trace_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .trace_valid    (trace_valid),
    .trace_pc       (trace_pc),
    .trace_instr    (trace_instr),
    .clear_overflow (clear_overflow),
    .uart_tx        (uart_tx),
    .busy           (busy),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .dropped_count  (dropped_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Byte b of the frame carrying record rec.
  function automatic logic [7:0] frame_byte(input logic [63:0] rec, input int b);
    logic [7:0] x;
    x = 8'h00;
    if (b == 0) return 8'hA5;
    if (b <= 8) return 8'(rec >> (8 * (8 - b)));
    for (int i = 1; i <= 8; i++) x ^= 8'(rec >> (8 * (8 - i)));
    return x;
  endfunction

  // Expected line level from elapsed time inside the current frame.
  function automatic logic exp_line();
    int elapsed, k, pos;
    logic [7:0] byt;
    if (m_rem == 0) return 1'b1;
    elapsed = FRAME - m_rem;
    k   = elapsed / CPB;
    pos = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    byt = frame_byte(m_cur, k / 10);
    return byt[pos-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur  = '0;
    m_rem  = 0;
    m_ovf  = 1'b0;
    m_dcnt = 0;
  endtask

  // One clock edge of the model, using the inputs as currently driven.
  task automatic model_edge();
    bit pop;
    if (reset) begin
      model_reset();
      return;
    end
    pop = (m_rem == 0) && (m_q.size() > 0);
    if (pop) begin
      m_cur = m_q.pop_front();
      m_rem = FRAME;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (trace_valid && m_q.size() < DEPTH) begin
      m_q.push_back({trace_pc, trace_instr});
      if (clear_overflow) begin m_ovf = 1'b0; m_dcnt = 0; end
    end else if (trace_valid) begin
      m_ovf  = 1'b1;
      m_dcnt = clear_overflow ? 1 : ((m_dcnt < 255) ? m_dcnt + 1 : 255);
    end else if (clear_overflow) begin
      m_ovf  = 1'b0;
      m_dcnt = 0;
    end
  endtask

  task automatic compare_all();
    check("uart_tx",       64'(uart_tx),       64'(exp_line()));
    check("busy",          64'(busy),          64'(m_rem > 0));
    check("fifo_level",    64'(fifo_level),    64'(m_q.size()));
    check("overflow",      64'(overflow),      64'(m_ovf));
    check("dropped_count", 64'(dropped_count), 64'(m_dcnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse(input logic [31:0] pc, input logic [31:0] instr);
    trace_valid = 1'b1;
    trace_pc    = pc;
    trace_instr = instr;
    step();
    trace_valid = 1'b0;
  endtask

  // Record one frame from the line and decode it at mid-bit.
  task automatic capture_frame(input logic [79:0] exp);
    logic line [FRAME];
    logic [7:0] got;
    int base;
    for (int i = 0; i < FRAME; i++) begin
      step();
      line[i] = uart_tx;
    end
    for (int b = 0; b < 10; b++) begin
      base = b * 10 * CPB + CPB / 2;
      check($sformatf("start_bit%0d", b), 64'(line[base]), 64'(0));
      for (int j = 0; j < 8; j++) got[j] = line[base + (1 + j) * CPB];
      check($sformatf("frame_byte%0d", b), 64'(got), 64'(exp[79-8*b -: 8]));
      check($sformatf("stop_bit%0d", b), 64'(line[base + 9 * CPB]), 64'(1));
    end
  endtask

  initial begin
    n_vectors      = 0;
    n_miscompares  = 0;
    clk            = 1'b0;
    reset          = 1'b1;
    trace_valid    = 1'b0;
    trace_pc       = '0;
    trace_instr    = '0;
    clear_overflow = 1'b0;
    model_reset();

    // Reset and idle line
    repeat (5) step();
    reset = 1'b0;
    repeat (100) step();

    // Single frame
    pulse(32'h00400000, 32'h20080005);
    capture_frame(80'hA5_00_40_00_00_20_08_00_05_6D);
    repeat (5) step();

    // Fill and overflow
    for (int i = 0; i < 6; i++) begin
      trace_valid = 1'b1;
      trace_pc    = 32'(i * 4);
      trace_instr = $urandom;
      step();
    end
    trace_valid = 1'b0;
    check("fill_level", 64'(fifo_level), 64'(4));
    check("fill_overflow", 64'(overflow), 64'(1));
    check("fill_dropped", 64'(dropped_count), 64'(1));
    repeat (5 * (FRAME + 1) + 10) step();
    check("drained_busy", 64'(busy), 64'(0));

    // Saturation and clear
    for (int i = 0; i < 305; i++) begin
      trace_valid = 1'b1;
      trace_pc    = $urandom;
      trace_instr = $urandom;
      step();
    end
    trace_valid = 1'b0;
    check("sat_dropped", 64'(dropped_count), 64'(255));
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("clear_overflow", 64'(overflow), 64'(0));
    check("clear_dropped", 64'(dropped_count), 64'(0));
    clear_overflow = 1'b1;
    trace_valid    = 1'b1;
    step();
    clear_overflow = 1'b0;
    trace_valid    = 1'b0;
    check("clr_drop_overflow", 64'(overflow), 64'(1));
    check("clr_drop_dropped", 64'(dropped_count), 64'(1));

    // Reset mid-frame with two records queued
    reset = 1'b1;
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      trace_valid = 1'b1;
      trace_pc    = $urandom;
      trace_instr = $urandom;
      step();
    end
    trace_valid = 1'b0;
    repeat (32 * CPB) step();
    check("pre_reset_level", 64'(fifo_level), 64'(2));
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_tx", 64'(uart_tx), 64'(1));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_level", 64'(fifo_level), 64'(0));
    repeat (3) step();
    reset = 1'b0;
    repeat (50) step();

    // Boundary values and checksum
    pulse(32'hFFFFFFFC, 32'hFFFFFFFF);
    capture_frame(80'hA5_FF_FF_FF_FC_FF_FF_FF_FF_03);

    // Randomized traffic, sparse then dense
    for (int i = 0; i < 8000; i++) begin
      trace_valid    = ($urandom_range(0, 99) < ((i < 4000) ? 1 : 25));
      trace_pc       = $urandom;
      trace_instr    = $urandom;
      clear_overflow = ($urandom_range(0, 49) == 0);
      step();
    end
    trace_valid    = 1'b0;
    clear_overflow = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_trace_uart_tx.md
Name: mips_trace_uart_tx

Overview:
Instruction-trace transmitter for the multi-cycle MIPS32 core. It captures a {PC, instruction} record each time the control FSM enters the fetch state and streams it off-chip over a UART 8N1 line. This puts in hardware the per-fetch PC/instruction reporting that the simulation bench prints. It sits beside the control unit in the top level. Its serial output feeds a board GPIO/UART pin, so a host can reconstruct execution on the MAX10 board.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2
FIFO_DEPTH, 4, record FIFO depth; power of two, ≥ 2
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
trace_valid  input  1  one-cycle pulse: control FSM entered fetch state
trace_pc  input  32  PC of fetched instruction, sampled with trace_valid
trace_instr  input  32  instruction word, sampled with trace_valid
clear_overflow  input  1  synchronous clear of overflow and dropped_count
uart_tx  output  1  serial line, idle high
busy  output  1  high while a frame is being shifted out
fifo_level  output  $clog2(FIFO_DEPTH)+1  records waiting (not in serializer)
overflow  output  1  sticky: a record was dropped
dropped_count  output  8  dropped records, saturates at 255

Behaviour:
- Reset (async, immediate on assertion):
  - uart_tx=1, busy=0, fifo_level=0, overflow=0, dropped_count=0.
  - FIFO pointers cleared and serializer in IDLE.
  - Reset mid-frame aborts the frame. The line returns high at once and queued records are discarded.
- Capture:
  - On a clk edge with trace_valid=1, the record {trace_pc, trace_instr} is written to the FIFO if not full.
  - If the FIFO is full and no pop occurs that cycle, the record is dropped. overflow is set, and dropped_count increments, saturating at 255.
  - Push and pop in the same cycle with the FIFO full: the push is accepted and the level is unchanged.
- Frame format: 10 bytes, each sent 8N1, LSB first.
  - Byte 0: SYNC_BYTE.
  - Bytes 1-4: PC, MSB byte first.
  - Bytes 5-8: instruction, MSB byte first.
  - Byte 9: XOR of bytes 1-8.
  - No gap between bytes within a frame.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Frame length is 100*CLKS_PER_BIT cycles.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the record, load the frame, set busy=1, and go to START. Otherwise hold uart_tx=1.
  - START: uart_tx=0 for one bit time, then go to DATA.
  - DATA: shift 8 bits, LSB first, then go to STOP.
  - STOP: uart_tx=1 for one bit time. If byte index < 9, increment it and go to START. Otherwise go to IDLE with busy=0.
- Timing and latency:
  - trace_valid sampled at edge E with FIFO empty and FSM idle: pop at edge E+1, uart_tx falls at edge E+1 and is held for CLKS_PER_BIT cycles.
  - Minimum of one IDLE cycle (uart_tx=1) between consecutive frames.
- clear_overflow:
  - On the edge it is sampled, overflow=0 and dropped_count=0.
  - If a drop occurs on the same edge, the drop wins over the clear: overflow=1, dropped_count=1.
- fifo_level excludes the record currently held in the serializer.
- trace_pc and trace_instr are ignored when trace_valid=0.

Test Plan:
- Reset values: hold reset for 5 cycles → uart_tx=1, busy=0, fifo_level=0, overflow=0, dropped_count=0. Release with no trace_valid for 100 cycles → uart_tx stays 1.
- Single frame, CLKS_PER_BIT=4: pulse trace_valid with PC=32'h00400000, instr=32'h20080005 → uart_tx falls 1 edge later and busy=1 for 400 cycles. Decoded bytes are A5 00 40 00 00 20 08 00 05 6D, each LSB first with start bit 0 and stop bit 1.
- Fill and overflow, FIFO_DEPTH=4: 6 consecutive trace_valid pulses with PC=0,4,8,12,16,20 → first 5 accepted (fifo_level peaks at 4), sixth dropped, overflow=1, dropped_count=1. Frames for PC 0,4,8,12,16 are emitted in order, each separated by ≥1 idle-high cycle.
- Saturation and clear: keep FIFO full and issue 300 trace_valid pulses → dropped_count=255. Pulse clear_overflow alone → overflow=0, count=0. Pulse clear_overflow coincident with a drop → overflow=1, count=1.
- Reset mid-frame: assert reset during byte 3 of a frame with 2 records queued → uart_tx=1 within the same cycle, busy=0, fifo_level=0. After release, no bits are emitted until a new trace_valid arrives, whose frame is then correct.
- Checksum and boundary values: PC=32'hFFFFFFFC, instr=32'hFFFFFFFF → bytes A5 FF FF FF FC FF FF FF FF 03.
